sam_mem_arbiter: RTL and testbench

- Shares one synchronous-read data/instruction RAM between the PicoRV32 native memory port and the SAM convolution accelerator's memory port.
- Replaces the ad-hoc mem_en_SAM selection with a small FSM.
- The FSM grants SAM priority, never preempts an in-flight CPU access, bounds CPU starvation, and flags out-of-range addresses.
- Sits in toplevel between the core, SAM and the RAM.

---
 rtl/sam_mem_pkg.sv | 16 +
 rtl/sam_run_counter.sv | 28 ++
 rtl/sam_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_sam_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sam_mem_pkg.sv
// Shared types and constants for the CPU/SAM memory arbiter.
package sam_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_SAM = 1'b1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CPU_RESP   = 2'd1,
    SAM_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/sam_run_counter.sv
// Saturating count of consecutive SAM grants taken while the CPU waits.
module sam_run_counter #(
  parameter int unsigned MAX_RUN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam int unsigned       CNT_W = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(MAX_RUN);

  logic [CNT_W-1:0] r_count;

  // Clear has priority over increment; the count holds once it reaches the limit.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign limit_hit = (r_count == LIMIT);

endmodule

// File: rtl/sam_mem_arbiter.sv
// Arbitrates a synchronous-read RAM between the PicoRV32 port and the SAM port.
// SAM has priority, CPU accesses are never preempted, and CPU starvation is bounded.
module sam_mem_arbiter
  import sam_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MAX_SAM_RUN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_instr,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              sam_en,
  input  logic [31:0]       sam_addr,
  input  logic [31:0]       sam_wdata,
  input  logic [3:0]        sam_wstrb,
  output logic              sam_ready,
  output logic [31:0]       sam_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wstrb,
  input  logic [31:0]       ram_rdata,
  output logic              owner,
  output logic              oob_err
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS * 4);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_grant_cpu;
  logic                w_grant_sam;
  logic                w_limit;
  logic                w_oob;
  logic                r_oob_pend;
  logic [DATA_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [STRB_W-1:0]   w_wstrb;
  logic                w_unused;

  // cpu_instr is informational only; byte-offset bits never reach the RAM.
  assign w_unused = ^{cpu_instr, w_addr[1:0]};

  sam_run_counter #(
    .MAX_RUN(MAX_SAM_RUN)
  ) u_run_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_grant_sam & cpu_valid),
    .clr      (w_grant_cpu | ~cpu_valid),
    .limit_hit(w_limit)
  );

  // State register; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_oob_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_oob_pend <= (w_grant_cpu | w_grant_sam) & w_oob;
    end
  end

  // Grant selection and next state; the state encodes who was granted last cycle.
  always_comb begin
    w_grant_cpu = 1'b0;
    w_grant_sam = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_limit)     w_grant_cpu = cpu_valid;
        else if (sam_en) w_grant_sam = 1'b1;
        else             w_grant_cpu = cpu_valid;
      end
      CPU_RESP: begin
      end
      SAM_STREAM: begin
        if (w_limit) w_grant_cpu = cpu_valid;
        else         w_grant_sam = sam_en;
      end
      default: begin
      end
    endcase
    if (reset) begin
      w_grant_cpu = 1'b0;
      w_grant_sam = 1'b0;
    end
    if (w_grant_sam)      w_state_nxt = SAM_STREAM;
    else if (w_grant_cpu) w_state_nxt = CPU_RESP;
    else                  w_state_nxt = IDLE;
  end

  // RAM-side mux from the granted requester; out-of-range accesses never strobe the RAM.
  always_comb begin
    w_addr    = w_grant_sam ? sam_addr  : cpu_addr;
    w_wdata   = w_grant_sam ? sam_wdata : cpu_wdata;
    w_wstrb   = w_grant_sam ? sam_wstrb : cpu_wstrb;
    w_oob     = ({1'b0, w_addr} >= ADDR_LIMIT);
    ram_en    = (w_grant_cpu | w_grant_sam) & ~w_oob;
    ram_addr  = ram_en ? w_addr[ADDR_W+1:2] : '0;
    ram_wdata = ram_en ? w_wdata : '0;
    ram_wstrb = ram_en ? w_wstrb : '0;
    owner     = w_grant_sam ? OWNER_SAM : OWNER_CPU;
  end

  // Response side: RAM data arrives the cycle after the grant, masked to 0 for out-of-range.
  always_comb begin
    cpu_ready = (r_state == CPU_RESP);
    sam_ready = (r_state == SAM_STREAM);
    oob_err   = r_oob_pend;
    cpu_rdata = (cpu_ready && !r_oob_pend) ? ram_rdata : '0;
    sam_rdata = (sam_ready && !r_oob_pend) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_sam_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized CPU/SAM traffic checked every cycle against a transaction-level model.
module tb_sam_mem_arbiter;

  localparam int unsigned MEM_WORDS = 256;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MAX_RUN   = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_valid = 1'b0;
  logic              cpu_instr = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [3:0]        cpu_wstrb = '0;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;
  logic              sam_en = 1'b0;
  logic [31:0]       sam_addr = '0;
  logic [31:0]       sam_wdata = '0;
  logic [3:0]        sam_wstrb = '0;
  logic              sam_ready;
  logic [31:0]       sam_rdata;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wstrb;
  logic [31:0]       ram_rdata = '0;
  logic              owner;
  logic              oob_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sam_mem_arbiter #(
    .MEM_WORDS  (MEM_WORDS),
    .ADDR_W     (ADDR_W),
    .MAX_SAM_RUN(MAX_RUN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_valid(cpu_valid),
    .cpu_instr(cpu_instr),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata),
    .sam_en   (sam_en),
    .sam_addr (sam_addr),
    .sam_wdata(sam_wdata),
    .sam_wstrb(sam_wstrb),
    .sam_ready(sam_ready),
    .sam_rdata(sam_rdata),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb),
    .ram_rdata(ram_rdata),
    .owner    (owner),
    .oob_err  (oob_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned i);
    case (i)
      10: return 32'd3;
      11: return 32'd3;
      12: return 32'd4;
      13: return 32'd5;
      14: return 32'd3;
      18: return 32'd0;
      default: return i * 32'h9E37_79B9;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return $urandom | 32'h0000_0400;
    if ($urandom_range(0, 1) == 1) return ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
    return ($urandom_range(224, 255) << 2) | $urandom_range(0, 3);
  endfunction

  // Synchronous-read RAM seen by the DUT.
  logic [31:0] ram_mem [MEM_WORDS];
  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) ram_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_en) begin
        ram_rdata <= ram_mem[ram_addr];
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // Reference model: decides each cycle's grant from the arbitration rules, keeps
  // its own copy of memory, and predicts next cycle's response from that grant.
  logic [31:0] m_mem [MEM_WORDS];
  initial begin
    int          g;
    int          m_pend_who;
    logic        m_pend_oob;
    logic        m_pend_wr;
    logic [31:0] m_pend_data;
    int          m_run;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        oob;
    logic        en;
    int unsigned widx;
    for (int i = 0; i < int'(MEM_WORDS); i++) m_mem[i] = init_word(i);
    m_pend_who = 0; m_pend_oob = 1'b0; m_pend_wr = 1'b0; m_pend_data = '0; m_run = 0;
    forever begin
      @(negedge clk);
      chk("cpu_ready", cpu_ready, m_pend_who == 1);
      chk("sam_ready", sam_ready, m_pend_who == 2);
      chk("oob_err", oob_err, m_pend_oob);
      if (m_pend_who == 1 && !m_pend_wr) chk("cpu_rdata", cpu_rdata, m_pend_data);
      if (m_pend_who == 2 && !m_pend_wr) chk("sam_rdata", sam_rdata, m_pend_data);

      g = 0;
      if (!reset && m_pend_who != 1) begin
        if (m_run >= int'(MAX_RUN)) g = cpu_valid ? 1 : 0;
        else if (sam_en)            g = 2;
        else if (m_pend_who != 2 && cpu_valid) g = 1;
      end
      a    = (g == 2) ? sam_addr  : cpu_addr;
      wd   = (g == 2) ? sam_wdata : cpu_wdata;
      ws   = (g == 2) ? sam_wstrb : cpu_wstrb;
      oob  = a >= MEM_WORDS * 4;
      en   = (g != 0) && !oob;
      widx = a >> 2;

      chk("ram_en", ram_en, en);
      chk("owner", owner, g == 2);
      if (en) begin
        chk("ram_addr", ram_addr, widx);
        chk("ram_wstrb", ram_wstrb, ws);
        if (ws != 0) chk("ram_wdata", ram_wdata, wd);
      end

      m_pend_who  = g;
      m_pend_oob  = (g != 0) && oob;
      m_pend_wr   = (ws != 0);
      m_pend_data = en ? m_mem[widx] : 32'h0;
      if (en)
        for (int b = 0; b < 4; b++)
          if (ws[b]) m_mem[widx][8*b +: 8] = wd[8*b +: 8];

      if (reset || g == 1 || !cpu_valid) m_run = 0;
      else if (g == 2 && m_run < int'(MAX_RUN)) m_run = m_run + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_valid = 1'b0; sam_en = 1'b0; cpu_wstrb = '0; sam_wstrb = '0;
    repeat (n) step();
  endtask

  logic        rec_c [13];
  logic        rec_s [13];
  logic [31:0] burst_addr [4];
  logic [31:0] burst_exp  [4];
  logic        go;

  initial begin
    burst_addr = '{32'h2C, 32'h30, 32'h34, 32'h38};
    burst_exp  = '{32'd3, 32'd4, 32'd5, 32'd3};

    // Reset state
    step(); step();
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_sam_ready", sam_ready, 0);
    chk("rst_owner", owner, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    reset = 1'b0;
    step();

    // CPU read of word 10
    cpu_valid = 1'b1; cpu_addr = 32'h28; cpu_wstrb = 4'b0000; #1;
    chk("rd_ram_en", ram_en, 1);
    chk("rd_ram_addr", ram_addr, 10);
    step();
    chk("rd_ready", cpu_ready, 1);
    chk("rd_rdata", cpu_rdata, 3);
    cpu_valid = 1'b0;
    step();
    chk("rd_ready_pulse", cpu_ready, 0);

    // CPU half-word write then readback
    cpu_valid = 1'b1; cpu_addr = 32'h48; cpu_wdata = 32'hAABB_CCDD; cpu_wstrb = 4'b0011; #1;
    chk("wr_ram_wstrb", ram_wstrb, 4'b0011);
    chk("wr_ram_addr", ram_addr, 18);
    chk("wr_ram_wdata", ram_wdata, 32'hAABB_CCDD);
    step();
    cpu_valid = 1'b0;
    step();
    cpu_valid = 1'b1; cpu_wstrb = 4'b0000;
    step();
    chk("wr_readback", cpu_rdata, 32'h0000_CCDD);
    cpu_valid = 1'b0;
    idle(2);

    // SAM burst of four reads
    sam_en = 1'b1; sam_addr = burst_addr[0]; #1;
    chk("burst_owner", owner, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("burst_ready", sam_ready, 1);
      chk("burst_rdata", sam_rdata, burst_exp[i]);
      if (i < 3) begin
        sam_addr = burst_addr[i+1]; #1;
        chk("burst_owner", owner, 1);
      end else begin
        sam_en = 1'b0;
      end
    end
    idle(2);

    // No preemption: SAM asks while the CPU response is pending
    cpu_valid = 1'b1; cpu_addr = 32'h28; cpu_wstrb = '0;
    step();
    sam_en = 1'b1; sam_addr = 32'h2C; sam_wstrb = '0; cpu_valid = 1'b0; #1;
    chk("np_cpu_ready", cpu_ready, 1);
    chk("np_cpu_rdata", cpu_rdata, 3);
    chk("np_ram_en", ram_en, 0);
    chk("np_owner", owner, 0);
    step();
    chk("np_sam_grant", ram_en, 1);
    chk("np_sam_owner", owner, 1);
    chk("np_sam_ready", sam_ready, 0);
    step();
    chk("np_sam_ready2", sam_ready, 1);
    chk("np_sam_rdata", sam_rdata, 3);
    idle(2);

    // Contention: SAM runs 8 grants, CPU granted in cycle 9
    cpu_valid = 1'b1; cpu_addr = 32'h28; cpu_wstrb = '0;
    sam_en = 1'b1; sam_addr = 32'h2C; sam_wstrb = '0;
    for (int k = 2; k <= 12; k++) begin
      step();
      rec_c[k] = cpu_ready;
      rec_s[k] = sam_ready;
      if (cpu_ready) cpu_valid = 1'b0;
    end
    chk("cont_sam_ready_c2", rec_s[2], 1);
    chk("cont_sam_ready_c9", rec_s[9], 1);
    chk("cont_cpu_ready_c9", rec_c[9], 0);
    chk("cont_cpu_ready_c10", rec_c[10], 1);
    chk("cont_sam_ready_c10", rec_s[10], 0);
    chk("cont_sam_ready_c11", rec_s[11], 0);
    chk("cont_sam_ready_c12", rec_s[12], 1);
    idle(2);

    // Out-of-range CPU read
    cpu_valid = 1'b1; cpu_addr = 32'h400; cpu_wstrb = '0; #1;
    chk("oob_ram_en", ram_en, 0);
    step();
    chk("oob_ready", cpu_ready, 1);
    chk("oob_rdata", cpu_rdata, 0);
    chk("oob_err", oob_err, 1);
    cpu_valid = 1'b0;
    step();
    chk("oob_err_pulse", oob_err, 0);

    // Reset in the middle of a SAM burst
    sam_en = 1'b1; sam_addr = 32'h30;
    step(); step();
    reset = 1'b1;
    step();
    chk("mrst_sam_ready", sam_ready, 0);
    chk("mrst_sam_rdata", sam_rdata, 0);
    chk("mrst_cpu_ready", cpu_ready, 0);
    chk("mrst_owner", owner, 0);
    chk("mrst_oob", oob_err, 0);
    chk("mrst_ram_en", ram_en, 0);
    reset = 1'b0;
    idle(2);

    // Randomized traffic; agents hold requests until their ready returns
    for (int c = 0; c < 4000; c++) begin
      step();
      reset = ($urandom_range(0, 399) == 0);
      if (cpu_ready) begin
        cpu_valid = 1'b0;
      end else if (!cpu_valid && $urandom_range(0, 2) == 0) begin
        cpu_valid = 1'b1;
        cpu_instr = 1'($urandom_range(0, 1));
        cpu_addr  = rand_addr();
        cpu_wdata = $urandom;
        cpu_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
      end
      if (!sam_en || sam_ready) begin
        go = sam_en ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        sam_en = go;
        if (go) begin
          sam_addr  = rand_addr();
          sam_wdata = $urandom;
          sam_wstrb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        end
      end
    end
    reset = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
